// File: rtl/disp_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
// Provides the page encoding, the blank-digit code and the BCD digit type.
package disp_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    SCORE = 2'd0,
    LINES = 2'd1,
    LEVEL = 2'd2,
    MSG   = 2'd3
  } page_e;

  // The segment driver renders any code 0xA-0xF as dark; 0xF is the chosen blank.
  localparam bcd_t BLANK_DIGIT = 4'hF;

  // Replace leading zero nibbles with BLANK_DIGIT; the units nibble always shows.
  function automatic logic [15:0] blank_leading(input logic [15:0] d);
    logic z3, z2, z1;
    z3 = (d[15:12] == 4'h0);
    z2 = z3 && (d[11:8] == 4'h0);
    z1 = z2 && (d[7:4] == 4'h0);
    return {z3 ? BLANK_DIGIT : bcd_t'(d[15:12]),
            z2 ? BLANK_DIGIT : bcd_t'(d[11:8]),
            z1 ? BLANK_DIGIT : bcd_t'(d[7:4]),
            bcd_t'(d[3:0])};
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running digit-scan prescaler.
// Ports: clk, rst (sync, active-high) in; scan_tick out - one-cycle strobe in
// the cycle the internal count equals REFRESH_DIV-1 (first at post-reset cycle
// REFRESH_DIV-1). REFRESH_DIV must be >= 2.
module scan_prescaler #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic scan_tick
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);

  logic [CW-1:0] count;

  // Strobe is registered one count early so it coincides with count == DIV-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      scan_tick <= 1'b0;
    end else begin
      if (count == CW'(REFRESH_DIV - 1)) count <= '0;
      else                               count <= count + CW'(1);
      scan_tick <= (count == CW'(REFRESH_DIV - 2));
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Time-shares a 4-digit seven-segment display between score, lines and level
// counters plus a preemptive one-shot message channel.
// Ports: clk, rst (sync, active-high); score_bcd/lines_bcd/level_bcd [15:0]
// live BCD sources; msg_req/msg_digits message request and payload;
// msg_ack accept pulse (asserted combinationally in the accept cycle);
// scan_tick digit-scan strobe; digits [15:0] registered display bus;
// page [1:0] current page (0 SCORE, 1 LINES, 2 LEVEL, 3 MSG).
// Build option: DISP_LZB_EN enables leading-zero blanking on rotating pages.
module display_scheduler #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned PAGE_TICKS  = 1024,
  parameter int unsigned MSG_TICKS   = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] score_bcd,
  input  logic [15:0] lines_bcd,
  input  logic [15:0] level_bcd,
  input  logic        msg_req,
  input  logic [15:0] msg_digits,
  output logic        msg_ack,
  output logic        scan_tick,
  output logic [15:0] digits,
  output logic [1:0]  page
);
  import disp_pkg::*;

  localparam logic [1:0] ST_SCORE = SCORE;
  localparam logic [1:0] ST_LINES = LINES;
  localparam logic [1:0] ST_LEVEL = LEVEL;
  localparam logic [1:0] ST_MSG   = MSG;

  localparam int unsigned PTW = (PAGE_TICKS > 1) ? $clog2(PAGE_TICKS) : 1;
  localparam int unsigned MTW = (MSG_TICKS > 1) ? $clog2(MSG_TICKS) : 1;

  logic [1:0]     state, state_next;
  logic [1:0]     ret_page, ret_page_next;
  logic [PTW-1:0] page_timer, page_timer_next;
  logic [MTW-1:0] msg_timer, msg_timer_next;
  logic [15:0]    msg_latch, msg_latch_next;
  logic [15:0]    rot_src;
  logic [15:0]    digits_next;

  scan_prescaler #(.REFRESH_DIV(REFRESH_DIV)) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .scan_tick (scan_tick)
  );

  // Page state register plus timers and message latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_SCORE;
      ret_page   <= ST_SCORE;
      page_timer <= '0;
      msg_timer  <= '0;
      msg_latch  <= '0;
      digits     <= '0;
    end else begin
      state      <= state_next;
      ret_page   <= ret_page_next;
      page_timer <= page_timer_next;
      msg_timer  <= msg_timer_next;
      msg_latch  <= msg_latch_next;
      digits     <= digits_next;
    end
  end

  // Next-state: message accept preempts any page advance in the same cycle.
  always_comb begin
    state_next      = state;
    ret_page_next   = ret_page;
    page_timer_next = page_timer;
    msg_timer_next  = msg_timer;
    msg_latch_next  = msg_latch;
    msg_ack         = 1'b0;
    case (state)
      ST_MSG: begin
        if (scan_tick) begin
          if (msg_timer == MTW'(MSG_TICKS - 1)) begin
            state_next      = ret_page;
            page_timer_next = '0;
            msg_timer_next  = '0;
          end else begin
            msg_timer_next = msg_timer + MTW'(1);
          end
        end
      end
      default: begin
        if (msg_req && !rst) begin
          msg_ack        = 1'b1;
          msg_latch_next = msg_digits;
          ret_page_next  = state;
          state_next     = ST_MSG;
          msg_timer_next = '0;
        end else if (scan_tick) begin
          if (page_timer == PTW'(PAGE_TICKS - 1)) begin
            page_timer_next = '0;
            case (state)
              ST_SCORE: state_next = ST_LINES;
              ST_LINES: state_next = ST_LEVEL;
              default:  state_next = ST_SCORE;
            endcase
          end else begin
            page_timer_next = page_timer + PTW'(1);
          end
        end
      end
    endcase
  end

  // Display mux: live rotating sources, latched payload on the message page.
  always_comb begin
    rot_src = '0;
    case (state)
      ST_SCORE: rot_src = score_bcd;
      ST_LINES: rot_src = lines_bcd;
      ST_LEVEL: rot_src = level_bcd;
      default:  rot_src = '0;
    endcase
    if (state == ST_MSG) begin
      digits_next = msg_latch;
    end else begin
`ifdef DISP_LZB_EN
      digits_next = blank_leading(rot_src);
`else
      digits_next = rot_src;
`endif
    end
  end

  assign page = state;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed self-checking bench for display_scheduler with
// REFRESH_DIV=4, PAGE_TICKS=3, MSG_TICKS=2. Cycle 0 is the first cycle with
// rst released; all expected values are hand-derived cycle numbers.
module tb_display_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] score_bcd, lines_bcd, level_bcd;
  logic        msg_req;
  logic [15:0] msg_digits;
  logic        msg_ack;
  logic        scan_tick;
  logic [15:0] digits;
  logic [1:0]  page;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  display_scheduler #(.REFRESH_DIV(4), .PAGE_TICKS(3), .MSG_TICKS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .score_bcd  (score_bcd),
    .lines_bcd  (lines_bcd),
    .level_bcd  (level_bcd),
    .msg_req    (msg_req),
    .msg_digits (msg_digits),
    .msg_ack    (msg_ack),
    .scan_tick  (scan_tick),
    .digits     (digits),
    .page       (page)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Expected rendering of a rotating-page value in this build.
  function automatic logic [15:0] shown(input logic [15:0] v);
    logic [15:0] r;
    r = v;
`ifdef DISP_LZB_EN
    for (int i = 3; i >= 1; i--) begin
      if (v[i*4 +: 4] != 4'h0) break;
      r[i*4 +: 4] = 4'hF;
    end
`endif
    return r;
  endfunction

  function automatic logic [1:0] rot_page(input int c);
    if (c < 12) return 2'd0;
    if (c < 24) return 2'd1;
    if (c < 36) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [15:0] src_of(input logic [1:0] p);
    case (p)
      2'd0:    return shown(score_bcd);
      2'd1:    return shown(lines_bcd);
      default: return shown(level_bcd);
    endcase
  endfunction

  initial begin
    rst        = 1'b1;
    score_bcd  = 16'h1234;
    lines_bcd  = 16'h0056;
    level_bcd  = 16'h0007;
    msg_req    = 1'b0;
    msg_digits = 16'h0000;
    step(2);
    rst = 1'b0;
    cyc = 0;

    // Reset state in cycle 0
    check("rst_page", 16'(page), 16'd0);
    check("rst_digits", digits, 16'h0000);
    check("rst_ack", 16'(msg_ack), 16'd0);

    // Free rotation: ticks every 4 cycles, page advances every 3 ticks
    for (int c = 0; c < 48; c++) begin
      if (c > 0) step(1);
      check("rot_tick", 16'(scan_tick), 16'((c % 4) == 3));
      check("rot_page", 16'(page), 16'(rot_page(c)));
      if (c > 0) check("rot_digits", digits, src_of(rot_page(c - 1)));
    end

    // Message during LINES (cycle 48)
    step(1);
    msg_req = 1'b1; msg_digits = 16'hDEAD; #1;
    check("b_ack", 16'(msg_ack), 16'd1);
    check("b_page_acc", 16'(page), 16'd1);
    step(1);
    msg_req = 1'b0; msg_digits = 16'h1111; #1;
    check("b_page_msg", 16'(page), 16'd3);
    check("b_ack_once", 16'(msg_ack), 16'd0);
    step(1);                                   // 50
    check("b_digits", digits, 16'hDEAD);
    step(5);                                   // 55: second message tick
    check("b_page_55", 16'(page), 16'd3);
    check("b_tick_55", 16'(scan_tick), 16'd1);
    check("b_digits_55", digits, 16'hDEAD);
    step(1);                                   // 56: back to LINES
    check("b_ret_page", 16'(page), 16'd1);
    step(1);                                   // 57
    check("b_ret_digits", digits, shown(16'h0056));
    step(10);                                  // 67: third tick of fresh page
    check("b_full_67", 16'(page), 16'd1);
    check("b_tick_67", 16'(scan_tick), 16'd1);
    step(1);                                   // 68
    check("b_adv_68", 16'(page), 16'd2);

    // Request coinciding with SCORE->LINES advance (cycle 91)
    step(23);
    check("c_tick_91", 16'(scan_tick), 16'd1);
    check("c_page_91", 16'(page), 16'd0);
    msg_req = 1'b1; msg_digits = 16'h0012; #1;
    check("c_ack", 16'(msg_ack), 16'd1);
    step(1);                                   // 92: second request held
    msg_digits = 16'h0BAD; #1;
    check("c_page_msg", 16'(page), 16'd3);
    check("d_no_ack_92", 16'(msg_ack), 16'd0);
    step(1);                                   // 93
    check("c_msg_unblanked", digits, 16'h0012);
    step(6);                                   // 99
    check("d_page_99", 16'(page), 16'd3);
    check("d_no_ack_99", 16'(msg_ack), 16'd0);
    step(1);                                   // 100: returned to SCORE
    check("c_ret_score", 16'(page), 16'd0);
    check("d_ack_ret", 16'(msg_ack), 16'd1);
    step(1);                                   // 101
    msg_req = 1'b0; #1;
    check("d_reenter", 16'(page), 16'd3);
    check("d_score_digits", digits, shown(16'h1234));
    step(1);                                   // 102
    check("d_msg2_digits", digits, 16'h0BAD);
    step(6);                                   // 108
    check("d_ret_108", 16'(page), 16'd0);

    // Live tracking and blanking of small values
    step(2);                                   // 110
    score_bcd = 16'h0009;
    step(1);                                   // 111
    check("e_live_score", digits, shown(16'h0009));
    step(14);                                  // 125
    check("e_page_125", 16'(page), 16'd1);
    level_bcd = 16'h0000;
    step(7);                                   // 132
    check("e_page_132", 16'(page), 16'd2);
    step(1);                                   // 133
    check("e_level_zero", digits, shown(16'h0000));

    // Reset during a message
    step(1);                                   // 134
    msg_req = 1'b1; msg_digits = 16'hCAFE; #1;
    check("f_ack", 16'(msg_ack), 16'd1);
    step(1);                                   // 135
    msg_req = 1'b0; #1;
    check("f_page_msg", 16'(page), 16'd3);
    step(2);                                   // 137
    rst = 1'b1;
    step(1);                                   // 138: post-reset cycle 0
    rst = 1'b0; #1;
    check("f_rst_page", 16'(page), 16'd0);
    check("f_rst_digits", digits, 16'h0000);
    check("f_rst_ack", 16'(msg_ack), 16'd0);
    check("f_rst_tick", 16'(scan_tick), 16'd0);
    step(2);                                   // 140
    check("f_tick_140", 16'(scan_tick), 16'd0);
    check("f_digits_140", digits, shown(16'h0009));
    step(1);                                   // 141
    check("f_tick_141", 16'(scan_tick), 16'd1);
    check("f_page_141", 16'(page), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
